// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with input FIFO, configurable width, parity,
//               stop bits and baud prescaler; frames sent back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PRESC_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DWIDTH-1:0]                 p_data,
    input  logic                              data_valid,
    output logic                              data_ready,
    input  logic                              par_en,
    input  logic                              par_typ,
    input  logic                              stop2,
    input  logic [PRESC_W-1:0]                baud_div,
    output logic                              tx_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_BIT_W  = $clog2(DWIDTH);

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DWIDTH - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP1  = 3'd4;
    localparam logic [2:0] c_S_STOP2  = 3'd5;

    // ------------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------------
    logic [DWIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;

    // Readiness depends only on the stored count, so a same-cycle pop never frees a slot.
    assign data_ready = (r_count != c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = data_valid & data_ready;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= p_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_BIT_W-1:0] r_bit_idx;
    logic [PRESC_W-1:0] r_baud_cnt;
    logic [DWIDTH-1:0]  r_word;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_stop2;
    logic [PRESC_W-1:0] r_div;
    logic               r_tx;
    logic               r_busy;

    logic [2:0]         w_state_nxt;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [PRESC_W-1:0] w_cnt_nxt;
    logic               w_frame_end;
    logic               w_tx_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_S_IDLE;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_word     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_div      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != c_S_IDLE);
            if (w_pop) begin
                r_word    <= r_mem[r_rd_ptr];
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
                r_stop2   <= stop2;
                r_div     <= baud_div;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_cnt_nxt   = r_baud_cnt;
        w_frame_end = 1'b0;
        w_pop       = 1'b0;

        if (r_state == c_S_IDLE) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = c_S_START;
                w_cnt_nxt   = '0;
            end
        end else if (r_baud_cnt == r_div) begin
            w_cnt_nxt = '0;
            case (r_state)
                c_S_START: begin
                    w_state_nxt = c_S_DATA;
                    w_bit_nxt   = '0;
                end
                c_S_DATA: begin
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = r_par_en ? c_S_PARITY : c_S_STOP1;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_BIT_W'(1);
                    end
                end
                c_S_PARITY: w_state_nxt = c_S_STOP1;
                c_S_STOP1: begin
                    if (r_stop2) begin
                        w_state_nxt = c_S_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
                c_S_STOP2: w_frame_end = 1'b1;
                default:   w_state_nxt = c_S_IDLE;
            endcase
        end else begin
            w_cnt_nxt = r_baud_cnt + PRESC_W'(1);
        end

        // Chain straight into the next start bit when more words are queued.
        if (w_frame_end) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = c_S_START;
            end else begin
                w_state_nxt = c_S_IDLE;
            end
        end

        case (w_state_nxt)
            c_S_START:  w_tx_nxt = 1'b0;
            c_S_DATA:   w_tx_nxt = r_word[w_bit_nxt];
            c_S_PARITY: w_tx_nxt = r_par_typ ? ~^r_word : ^r_word;
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo using a per-cycle
//               expected-line-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          data_ready;
    logic          par_en;
    logic          par_typ;
    logic          stop2;
    logic [PW-1:0] baud_div;
    logic          tx_out;
    logic          busy;
    logic [3:0]    fifo_count;

    int   checks = 0;
    int   errors = 0;
    logic exp_q [$];
    logic mon_en = 1'b0;
    logic prev_busy = 1'b0;
    int   run = 0;
    int   last_run = 0;

    uart_tx_fifo #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESC_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .baud_div   (baud_div),
        .tx_out     (tx_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_level(input logic b, input int div);
        repeat (div + 1) exp_q.push_back(b);
    endtask

    // Expected line levels for one frame, one entry per clock cycle.
    task automatic build_frame(input logic [DW-1:0] w, input logic pe, input logic pt,
                               input logic s2, input int div);
        add_level(1'b0, div);
        for (int i = 0; i < DW; i++) add_level(w[i], div);
        if (pe) add_level(pt ? ~(^w) : (^w), div);
        add_level(1'b1, div);
        if (s2) add_level(1'b1, div);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        logic rdy;
        p_data     = w;
        data_valid = 1'b1;
        rdy        = data_ready;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        if (rdy) build_frame(w, par_en, par_typ, stop2, int'(baud_div));
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (!(busy === 1'b0 && exp_q.size() == 0) && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, (busy === 1'b0 && exp_q.size() == 0), 1);
    endtask

    // Line monitor: every busy cycle consumes one expected level.
    always @(negedge clk) begin
        if (!mon_en) begin
            run       = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy === 1'b1) begin
                run++;
                check("busy_extra", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_bit", tx_out, exp_q.pop_front());
            end else begin
                if (run != 0) begin
                    last_run = run;
                    run      = 0;
                end
                check("tx_idle", tx_out, 1'b1);
                if (prev_busy) check("busy_gap", (exp_q.size() == 0), 1);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        baud_div   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", data_ready, 1'b1);
        check("rst_count", fifo_count, 4'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // T1: 8N1, divider 0, plus start latency
        push_word(8'hA3);
        check("t1_lat_busy0", busy, 1'b0);
        check("t1_lat_count1", fifo_count, 4'd1);
        @(posedge clk);
        #1;
        check("t1_lat_busy1", busy, 1'b1);
        check("t1_lat_tx0", tx_out, 1'b0);
        check("t1_lat_count0", fifo_count, 4'd0);
        wait_idle("t1_idle", 50);
        check("t1_len", last_run, 10);

        // T2: odd parity
        par_en  = 1'b1;
        par_typ = 1'b1;
        push_word(8'hAB);
        wait_idle("t2_idle", 50);
        check("t2_len", last_run, 11);

        // T3: even parity
        par_typ = 1'b0;
        push_word(8'h61);
        wait_idle("t3_idle", 50);
        check("t3_len", last_run, 11);

        // T4: divider 3, two stop bits, divider changed mid-frame
        baud_div = 16'd3;
        stop2    = 1'b1;
        push_word(8'h1A);
        repeat (12) @(posedge clk);
        #1;
        baud_div = 16'd1;
        wait_idle("t4_idle", 100);
        check("t4_len", last_run, 48);
        par_en = 1'b0;
        stop2  = 1'b0;
        push_word(8'h55);
        wait_idle("t4b_idle", 100);
        check("t4b_len", last_run, 20);

        // T5: fill the FIFO while a frame is in flight
        baud_div = 16'd15;
        for (int i = 0; i < 10; i++) begin
            logic rdy;
            p_data     = 8'h30 + 8'(i * 7);
            data_valid = 1'b1;
            check("t5_ready", data_ready, (i < 9) ? 1'b1 : 1'b0);
            rdy = data_ready;
            @(posedge clk);
            #1;
            if (rdy) build_frame(p_data, par_en, par_typ, stop2, int'(baud_div));
        end
        data_valid = 1'b0;
        check("t5_count_full", fifo_count, 4'd8);
        check("t5_ready_low", data_ready, 1'b0);
        wait_idle("t5_idle", 1600);
        check("t5_len", last_run, 9 * 160);

        // T6: reset during the data bits of the second queued frame
        baud_div = 16'd3;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        repeat (60) @(posedge clk);
        #1;
        check("t6_busy_pre", busy, 1'b1);
        check("t6_count_pre", fifo_count, 4'd1);
        mon_en = 1'b0;
        rst    = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("t6_tx", tx_out, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_count", fifo_count, 4'd0);
        check("t6_ready", data_ready, 1'b1);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        push_word(8'h3C);
        wait_idle("t6_idle", 100);
        check("t6_len", last_run, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
